// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-buffered UART transmitter: FSM state
// encoding, default clock/bit-rate constants and the bit-period calculation.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int DEFAULT_CLK_HZ   = 1_000_000;
    localparam int DEFAULT_BIT_RATE = 115_200;

    // Clocks per serial bit; integer division truncates toward zero.
    function automatic int calc_cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through output. Occupancy is tracked
// by an explicit count; full/empty come from that count, never the pointers.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("sync_fifo: DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_push_ok;
    logic             w_pop_ok;
    logic [CNT_W-1:0] w_count_next;

    // Qualify requests against current occupancy and compute the next count;
    // a push while full is dropped even if a pop frees a slot this cycle.
    always_comb begin
        w_push_ok    = push & ~r_full;
        w_pop_ok     = pop & ~r_empty;
        w_count_next = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_push_ok && w_pop_ok) begin
            w_count_next = r_count - CNT_W'(1);
        end else begin
            w_count_next = r_count;
        end
    end

    // Pointers wrap naturally modulo DEPTH; flags are registered from the next count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(DEPTH));
            r_empty <= (w_count_next == {CNT_W{1'b0}});
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push_ok && !reset) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = r_full;
    assign empty = r_empty;

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO. The FSM pops one byte in IDLE,
// then sends start, eight data bits LSB first, and stop. The serial line and
// busy flag are registered from the current state, so they trail it by a cycle.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = DEFAULT_CLK_HZ,
    parameter int BIT_RATE   = DEFAULT_BIT_RATE,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    input  logic                          ovf_clr,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          tx_busy,
    output logic                          uart_txd
);

    localparam int CYCLES_PER_BIT = calc_cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int BAUD_W         = (CYCLES_PER_BIT < 2) ? 1 : $clog2(CYCLES_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CYCLES_PER_BIT - 1);

    generate
        if (CYCLES_PER_BIT < 2) begin : g_bad_rate
            $error("uart_tx_fifo: CLK_HZ/BIT_RATE must be at least 2");
        end
    endgenerate

    tx_state_e         r_state;
    tx_state_e         w_state_next;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [BAUD_W-1:0] w_baud_next;
    logic [2:0]        r_bit_idx;
    logic [2:0]        w_bit_next;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_next;
    logic              r_txd;
    logic              r_busy;
    logic              r_overflow;
    logic              w_txd_next;
    logic              w_pop;
    logic              w_bit_end;

    logic [7:0]                  w_fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
    logic                        w_fifo_full;
    logic                        w_fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .pop   (w_pop),
        .din   (wr_data),
        .dout  (w_fifo_dout),
        .count (w_fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign w_bit_end = (r_baud_cnt == BAUD_LAST);

    // Next-state, baud/bit counters, shift register and line level for the frame FSM.
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud_cnt;
        w_bit_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        w_txd_next   = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_txd_next  = 1'b1;
                w_baud_next = {BAUD_W{1'b0}};
                w_bit_next  = 3'd0;
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_fifo_dout;
                    w_state_next = ST_START;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_START: begin
                w_txd_next = 1'b0;
                if (w_bit_end) begin
                    w_baud_next  = {BAUD_W{1'b0}};
                    w_state_next = ST_DATA;
                end else begin
                    w_baud_next = r_baud_cnt + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                w_txd_next = r_shift[0];
                if (w_bit_end) begin
                    w_baud_next  = {BAUD_W{1'b0}};
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_bit_next   = 3'd0;
                        w_state_next = ST_STOP;
                    end else begin
                        w_bit_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud_cnt + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                w_txd_next = 1'b1;
                if (w_bit_end) begin
                    w_baud_next  = {BAUD_W{1'b0}};
                    w_state_next = ST_IDLE;
                end else begin
                    w_baud_next = r_baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                w_txd_next   = 1'b1;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register plus registered line, busy and sticky overflow (set beats clear).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= {BAUD_W{1'b0}};
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_idx  <= w_bit_next;
            r_shift    <= w_shift_next;
            r_txd      <= w_txd_next;
            r_busy     <= (r_state != ST_IDLE) || !w_fifo_empty;
            if (wr_en && w_fifo_full) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign full       = w_fifo_full;
    assign empty      = w_fifo_empty;
    assign fifo_count = w_fifo_count;
    assign overflow   = r_overflow;
    assign tx_busy    = r_busy;
    assign uart_txd   = r_txd;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a queue-based reference model checked
// every cycle, a mid-bit sampling UART receiver, and directed literal checks.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int CPB   = 8;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       ovf_clr = 1'b0;
    logic       full, empty, overflow, tx_busy, uart_txd;
    logic [4:0] fifo_count;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo #(
        .CLK_HZ     (1_000_000),
        .BIT_RATE   (115200),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .ovf_clr    (ovf_clr),
        .full       (full),
        .empty      (empty),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .tx_busy    (tx_busy),
        .uart_txd   (uart_txd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, frame timing as arithmetic on the pop edge.
    logic [7:0] mq[$];
    logic [7:0] rx_exp[$];
    int         edge_cnt    = 0;
    int         pop_edge    = -1000;
    int         next_pop_ok = 0;
    logic [7:0] cur         = 8'h00;
    logic       m_ovf       = 1'b0;
    logic       m_txd       = 1'b1;
    logic       m_busy      = 1'b0;
    bit         model_valid = 1'b0;
    bit         rx_en       = 1'b1;
    int         rx_frames   = 0;

    always @(posedge clk) begin : model_b
        int k;
        bit full_pre, nonempty_pre, active_pre;
        edge_cnt = edge_cnt + 1;
        if (reset) begin
            mq.delete();
            rx_exp.delete();
            pop_edge    = -1000;
            next_pop_ok = edge_cnt + 1;
            m_ovf       = 1'b0;
            m_txd       = 1'b1;
            m_busy      = 1'b0;
        end else begin
            full_pre     = (mq.size() == DEPTH);
            nonempty_pre = (mq.size() != 0);
            active_pre   = (edge_cnt - 1 >= pop_edge) && (edge_cnt - 1 <= pop_edge + 10*CPB - 1);
            k = edge_cnt - pop_edge;
            if (k >= 1 && k <= CPB)            m_txd = 1'b0;
            else if (k > CPB && k <= 9*CPB)    m_txd = cur[(k - CPB - 1) / CPB];
            else                               m_txd = 1'b1;
            m_busy = active_pre || nonempty_pre;
            if (edge_cnt >= next_pop_ok && nonempty_pre) begin
                cur         = mq.pop_front();
                pop_edge    = edge_cnt;
                next_pop_ok = edge_cnt + 10*CPB + 1;
                rx_exp.push_back(cur);
            end
            if (wr_en && full_pre)  m_ovf = 1'b1;
            else if (ovf_clr)       m_ovf = 1'b0;
            if (wr_en && !full_pre) mq.push_back(wr_data);
        end
        model_valid = 1'b1;
    end

    // Compare every DUT output against the model on the falling edge.
    always @(negedge clk) begin
        if (model_valid) begin
            check("txd",        uart_txd,   m_txd);
            check("tx_busy",    tx_busy,    m_busy);
            check("empty",      empty,      mq.size() == 0);
            check("full",       full,       mq.size() == DEPTH);
            check("fifo_count", fifo_count, mq.size());
            check("overflow",   overflow,   m_ovf);
        end
    end

    // UART receiver sampling mid-bit; decoded bytes must match model pop order.
    initial begin : rx_b
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rx_en && model_valid && !reset && uart_txd === 1'b0) begin
                repeat (CPB/2) @(negedge clk);
                check("rx_start", uart_txd, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = uart_txd;
                end
                repeat (CPB) @(negedge clk);
                check("rx_stop", uart_txd, 1'b1);
                check("rx_pending", rx_exp.size() > 0, 1'b1);
                if (rx_exp.size() > 0) check("rx_data", b, rx_exp.pop_front());
                rx_frames++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        wr_data = 8'($urandom);
    endtask

    task automatic do_write(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        wr_data = 8'($urandom);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (!(mq.size() == 0 && edge_cnt > pop_edge + 10*CPB + 10) && n < budget) begin
            tick();
            n++;
        end
        check(name, (mq.size() == 0 && edge_cnt > pop_edge + 10*CPB + 10), 1'b1);
    endtask

    initial begin : watchdog_b
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim_b
        logic [0:7] seq;
        int n;
        seq = 8'b1010_1010;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_txd", uart_txd, 1'b1);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_count", fifo_count, 5'd0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_busy", tx_busy, 1'b0);

        // Single byte 0x55: latency, bit pattern, stop, busy release
        do_write(8'h55);
        check("s1_empty_n0", empty, 1'b0);
        check("s1_count_n0", fifo_count, 5'd1);
        tick();
        check("s1_txd_n1", uart_txd, 1'b1);
        check("s1_empty_n1", empty, 1'b1);
        tick();
        check("s1_start_n2", uart_txd, 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) tick();
            check("s1_bit", uart_txd, seq[i]);
        end
        repeat (CPB) tick();
        check("s1_stop", uart_txd, 1'b1);
        repeat (7) tick();
        check("s1_busy_n81", tx_busy, 1'b1);
        tick();
        check("s1_busy_n82", tx_busy, 1'b0);

        // 17 back-to-back writes from idle
        for (int v = 0; v < 17; v++) begin
            do_write(8'(v));
            if (v == 1) check("s2_count_n1", fifo_count, 5'd1);
        end
        check("s2_count_peak", fifo_count, 5'd16);
        check("s2_full", full, 1'b1);
        check("s2_ovf", overflow, 1'b0);

        // Write while full on the cycle the FSM pops
        repeat (65) tick();
        do_write(8'hEE);
        check("s3_count", fifo_count, 5'd15);
        check("s3_full", full, 1'b0);
        check("s3_ovf", overflow, 1'b1);

        // Overflow set and clear together, then clear alone
        do_write(8'hC3);
        check("s5_count", fifo_count, 5'd16);
        check("s5_full", full, 1'b1);
        ovf_clr = 1'b1;
        do_write(8'h77);
        ovf_clr = 1'b0;
        check("s5_ovf_setwins", overflow, 1'b1);
        check("s5_count_drop", fifo_count, 5'd16);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("s5_ovf_clr", overflow, 1'b0);
        drain("s2_drain", 3000);

        // Reset during DATA bit 3 of 0xA5 with four bytes queued
        rx_en = 1'b0;
        do_write(8'hA5);
        do_write(8'h11);
        do_write(8'h22);
        do_write(8'h33);
        do_write(8'h44);
        check("s4_count", fifo_count, 5'd4);
        repeat (31) tick();
        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h3C;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr_en = 1'b0;
        check("s4_txd", uart_txd, 1'b1);
        check("s4_count0", fifo_count, 5'd0);
        check("s4_empty", empty, 1'b1);
        check("s4_busy", tx_busy, 1'b0);
        repeat (300) tick();
        check("s4_txd_quiet", uart_txd, 1'b1);
        check("s4_empty_quiet", empty, 1'b1);
        rx_en = 1'b1;

        // 256 random bytes through the receiver
        for (int i = 0; i < 256; i++) begin
            n = 0;
            while (mq.size() >= DEPTH && n < 500) begin
                tick();
                n++;
            end
            check("s6_space", mq.size() < DEPTH, 1'b1);
            do_write(8'($urandom));
        end
        drain("s6_drain", 3000);

        check("rx_frames", rx_frames, 275);
        check("rx_leftover", rx_exp.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 1_000_000, meaning the system clock frequency in Hz.
REQ-002 The block SHALL have parameter BIT_RATE, default 115200, meaning the serial bit rate in bits/s.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16, meaning the transmit FIFO entry count (power of 2, >= 2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous reset, active high.
REQ-006 The block SHALL have port wr_en, input, 1 bit: a one-cycle push strobe that writes wr_data into the FIFO.
REQ-007 The block SHALL have port wr_data, input, 8 bits: the byte to transmit.
REQ-008 The block SHALL have port ovf_clr, input, 1 bit: clears the overflow flag.
REQ-009 The block SHALL have port full, output, 1 bit: FIFO count == FIFO_DEPTH.
REQ-010 The block SHALL have port empty, output, 1 bit: FIFO count == 0.
REQ-011 The block SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1 bits: the number of bytes queued, excluding the frame in flight.
REQ-012 The block SHALL have port overflow, output, 1 bit: a sticky flag for a write attempted while full.
REQ-013 The block SHALL have port tx_busy, output, 1 bit: high when the FSM is not IDLE or the FIFO is non-empty.
REQ-014 The block SHALL have port uart_txd, output, 1 bit: the serial line, idle high, 8N1 format.

Function
REQ-015 The bit period SHALL be CYCLES_PER_BIT = CLK_HZ/BIT_RATE clocks, using integer truncation; elaboration SHALL fail if the result is < 2.
REQ-016 The FSM states SHALL be IDLE, START, DATA and STOP.
REQ-017 In IDLE, uart_txd SHALL be 1; if the FIFO is non-empty, the FSM SHALL pop the head into an 8-bit shift register and enter START on the next edge.
REQ-018 START SHALL drive 0 for CYCLES_PER_BIT clocks, then enter DATA.
REQ-019 DATA SHALL drive shift[0] for CYCLES_PER_BIT clocks per bit, LSB first, 8 bits, using a 3-bit bit index and shifting right after each bit, then enter STOP.
REQ-020 STOP SHALL drive 1 for CYCLES_PER_BIT clocks, then enter IDLE.
REQ-021 Frame-to-frame gap: IDLE SHALL last exactly 1 clock between back-to-back frames, giving 10*CYCLES_PER_BIT+1 clocks per frame.
REQ-022 uart_txd SHALL be registered (no combinational path from FSM decode).
REQ-023 Latency: a wr_en sampled at edge N into an empty FIFO with the FSM in IDLE SHALL make empty=0 after edge N and uart_txd=0 after edge N+2.
REQ-024 A write while full SHALL be discarded with no FIFO change, even if a pop occurs in the same cycle, and overflow SHALL be set.
REQ-025 A simultaneous push and pop when not full SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-026 overflow SHALL hold until ovf_clr; if set and clear coincide, set SHALL win.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with full/empty derived from the count, not the pointers.
REQ-028 wr_data changes while no write is occurring SHALL have no effect on the frame in flight.

Reset
REQ-029 On reset, the block SHALL set the FSM to IDLE, uart_txd=1, the FIFO pointers and count to 0, empty=1, full=0, overflow=0, tx_busy=0, and clear the baud counter and bit index.
REQ-030 Reset mid-frame SHALL abort the frame, drive uart_txd=1 after the reset edge, discard all queued bytes, and ignore wr_en while reset is high.

Structure
REQ-031 Shared package uart_pkg SHALL hold the FSM state encoding (2-bit), the default CLK_HZ/BIT_RATE constants, and the CYCLES_PER_BIT calculation.
REQ-032 The FIFO SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH; ports push/pop/din/dout/count/full/empty), with first-word-fall-through dout.
REQ-033 The baud counter and FSM SHALL live in uart_tx_fifo; there is no other sub-module.

Verification (CLK_HZ=1_000_000, BIT_RATE=115200, CYCLES_PER_BIT=8)
REQ-034 Bench SHALL cover: single wr 0x55 -> txd low after 2 edges, then bits 1,0,1,0,1,0,1,0 for 8 clocks each, stop high 8 clocks, tx_busy=0 at edge 82.
REQ-035 Bench SHALL cover: 17 consecutive writes of 0x00..0x10 starting idle -> first byte popped, count peaks at 16 with full=1, 0x10 dropped only if full at that edge, overflow=1 iff a write hit full; frames 81 clocks apart in order.
REQ-036 Bench SHALL cover: FIFO full and FSM popping with a write in the same cycle -> write dropped, count 15, overflow=1.
REQ-037 Bench SHALL cover: reset asserted during DATA bit 3 of 0xA5 with 4 bytes queued -> txd=1, count=0, empty=1 next edge; no further frames.
REQ-038 Bench SHALL cover: overflow=1 with ovf_clr and overflowing write in the same cycle -> overflow stays 1; ovf_clr alone next cycle -> 0.
REQ-039 Bench SHALL cover: a UART RX model sampling mid-bit decoding 256 random bytes -> zero mismatches, zero framing errors.
